// File: rtl/x_convergence_check_pkg.sv
// rtl/x_convergence_check_pkg.sv - shared types, defaults and helpers for the convergence check
// Holds the FSM state encoding, default parameter values, the saturation
// constant for the default element width and the element slice helper.
package x_convergence_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2
    } state_t;

    localparam int DEF_NUMBER_OF_EQUATIONS = 9;
    localparam int DEF_ELEMENT_WIDTH       = 32;
    localparam int DEF_STABLE_ITERATIONS   = 2;
    localparam int DEF_COUNTER_WIDTH       = 16;

    // Saturation value of an element-wide unsigned magnitude.
    localparam logic [DEF_ELEMENT_WIDTH-1:0] ELEMENT_ALL_ONES = '1;

    // Bit offset of element `index` inside a packed vector of `width`-bit elements.
    function automatic int element_lsb(input int index, input int width);
        return index * width;
    endfunction

endpackage

// File: rtl/x_convergence_check_if.sv
// rtl/x_convergence_check_if.sv - signal bundle between the iteration datapath and the convergence check
// master: drives start/x_new/x_prev/tolerance, observes results.
// slave:  the check itself; drives busy, done, write-back strobe/data and results.
interface x_convergence_check_if #(
    parameter int number_of_equations_per_cluster = 9,
    parameter int element_width                   = 32,
    parameter int counter_width                   = 16
);
    localparam int VEC_W = number_of_equations_per_cluster * element_width;

    logic                     start;
    logic [VEC_W-1:0]         x_new;
    logic [VEC_W-1:0]         x_prev;
    logic [element_width-1:0] tolerance;
    logic                     busy;
    logic                     prev_write_enable;
    logic [VEC_W-1:0]         prev_write_data;
    logic                     done;
    logic                     converged;
    logic [element_width-1:0] max_diff;
    logic [counter_width-1:0] iteration_count;

    modport master (
        output start, x_new, x_prev, tolerance,
        input  busy, prev_write_enable, prev_write_data, done, converged, max_diff, iteration_count
    );

    modport slave (
        input  start, x_new, x_prev, tolerance,
        output busy, prev_write_enable, prev_write_data, done, converged, max_diff, iteration_count
    );

endinterface

// File: rtl/x_convergence_check_abs_diff_sat.sv
// rtl/x_convergence_check_abs_diff_sat.sv - combinational saturated |a - b| of two signed elements
// Ports: a, b (signed two's complement, element_width bits) in;
//        abs_diff (unsigned, element_width bits) out.
module abs_diff_sat #(
    parameter int element_width = 32
) (
    input  logic [element_width-1:0] a,
    input  logic [element_width-1:0] b,
    output logic [element_width-1:0] abs_diff
);

    logic signed [element_width:0] diff;
    logic        [element_width:0] mag;

    // One extra bit keeps the subtraction exact for any pair of inputs.
    assign diff     = $signed({a[element_width-1], a}) - $signed({b[element_width-1], b});
    assign mag      = diff[element_width] ? -diff : diff;
    assign abs_diff = mag[element_width] ? '1 : mag[element_width-1:0];

endmodule

// File: rtl/x_convergence_check.sv
// rtl/x_convergence_check.sv - max |x_new - x_prev| scan, tolerance decision and xKold_prev write-back
// Ports: clk, reset (sync, active-high); bus (slave modport) carrying
//        start/x_new/x_prev/tolerance in and busy/done/prev_write_enable/
//        prev_write_data/converged/max_diff/iteration_count out.
module x_convergence_check
    import x_convergence_check_pkg::*;
#(
    parameter int number_of_equations_per_cluster = DEF_NUMBER_OF_EQUATIONS,
    parameter int element_width                   = DEF_ELEMENT_WIDTH,
    parameter int stable_iterations               = DEF_STABLE_ITERATIONS,
    parameter int counter_width                   = DEF_COUNTER_WIDTH
) (
    input logic                  clk,
    input logic                  reset,
    x_convergence_check_if.slave bus
);

    localparam int N     = number_of_equations_per_cluster;
    localparam int W     = element_width;
    localparam int VEC_W = N * W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SW    = $clog2(stable_iterations + 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic [VEC_W-1:0] new_snap;
    logic [VEC_W-1:0] prev_snap;
    logic [W-1:0]     tol_q;
    logic [W-1:0]     run_max;
    logic [W-1:0]     max_diff_q;
    logic [SW-1:0]    stable_cnt;
    logic             converged_q;
    logic [counter_width-1:0] iter_q;

    logic [W-1:0]     elem_new, elem_prev, elem_abs, final_max;
    logic [SW-1:0]    stable_next;
    logic             last_elem;
    int               elem_base;

    always_comb begin
        elem_base = element_lsb(int'(idx), W);
        elem_new  = new_snap[elem_base +: W];
        elem_prev = prev_snap[elem_base +: W];
    end

    abs_diff_sat #(.element_width(W)) u_abs_diff_sat (
        .a        (elem_new),
        .b        (elem_prev),
        .abs_diff (elem_abs)
    );

    // final_max already folds in the element being scanned this cycle, so the
    // last SCAN edge can publish results that are visible during DECIDE.
    assign last_elem = (idx == IDX_W'(N - 1));
    assign final_max = (elem_abs > run_max) ? elem_abs : run_max;

    always_comb begin
        stable_next = '0;
        if (final_max <= tol_q) begin
            stable_next = (stable_cnt >= SW'(stable_iterations)) ? stable_cnt : stable_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (bus.start) state_next = ST_SCAN;
            ST_SCAN:   if (last_elem) state_next = ST_DECIDE;
            ST_DECIDE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            new_snap    <= '0;
            prev_snap   <= '0;
            tol_q       <= '0;
            run_max     <= '0;
            max_diff_q  <= '0;
            stable_cnt  <= '0;
            converged_q <= 1'b0;
            iter_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        new_snap  <= bus.x_new;
                        prev_snap <= bus.x_prev;
                        tol_q     <= bus.tolerance;
                        run_max   <= '0;
                        idx       <= '0;
                    end
                end
                ST_SCAN: begin
                    run_max <= final_max;
                    idx     <= idx + IDX_W'(1);
                    if (last_elem) begin
                        max_diff_q  <= final_max;
                        stable_cnt  <= stable_next;
                        converged_q <= (stable_next >= SW'(stable_iterations));
                        if (iter_q != '1) iter_q <= iter_q + counter_width'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy              = (state != ST_IDLE);
    assign bus.done              = (state == ST_DECIDE);
    assign bus.prev_write_enable = (state == ST_DECIDE);
    assign bus.prev_write_data   = new_snap;
    assign bus.converged         = converged_q;
    assign bus.max_diff          = max_diff_q;
    assign bus.iteration_count   = iter_q;

endmodule

// File: tb/tb_x_convergence_check.sv
// tb/tb_x_convergence_check.sv - self-checking bench for x_convergence_check
module tb_x_convergence_check;
    import x_convergence_check_pkg::*;

    localparam int N     = 9;
    localparam int W     = 32;
    localparam int S     = 2;
    localparam int CW    = 16;
    localparam int VEC_W = N * W;

    typedef logic [VEC_W-1:0] vec_t;
    typedef struct {
        logic [W-1:0]  max_diff;
        logic          conv;
        logic [CW-1:0] iter;
        vec_t          wdata;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_stable = 0;
    int   m_iter   = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    x_convergence_check_if #(
        .number_of_equations_per_cluster(N), .element_width(W), .counter_width(CW)
    ) bus ();

    x_convergence_check #(
        .number_of_equations_per_cluster(N), .element_width(W),
        .stable_iterations(S), .counter_width(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t fill(input logic [W-1:0] v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] model_abs(input logic [W-1:0] a, input logic [W-1:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        if (d < 0) d = -d;
        if (d > longint'(ELEMENT_ALL_ONES)) return ELEMENT_ALL_ONES;
        return W'(d);
    endfunction

    task automatic model_push(input vec_t nv, input vec_t pv, input logic [W-1:0] tol);
        exp_t e;
        logic [W-1:0] mx, ad;
        mx = '0;
        for (int i = 0; i < N; i++) begin
            ad = model_abs(nv[i*W +: W], pv[i*W +: W]);
            if (ad > mx) mx = ad;
        end
        if (mx <= tol) m_stable = (m_stable >= S) ? S : m_stable + 1;
        else           m_stable = 0;
        if (m_iter < (1 << CW) - 1) m_iter++;
        e.max_diff = mx;
        e.conv     = (m_stable >= S);
        e.iter     = CW'(m_iter);
        e.wdata    = nv;
        sb.push_back(e);
    endtask

    task automatic compare_done();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_size", VEC_W'(sb.size()), VEC_W'(1));
        end else begin
            e = sb.pop_front();
            check("max_diff",        bus.max_diff,          e.max_diff);
            check("converged",       bus.converged,         e.conv);
            check("iteration_count", bus.iteration_count,   e.iter);
            check("prev_write_data", bus.prev_write_data,   e.wdata);
            check("pwe_with_done",   bus.prev_write_enable, 1'b1);
        end
    endtask

    task automatic run_check(input vec_t nv, input vec_t pv, input logic [W-1:0] tol, input bit mid_change);
        int lat;
        int pwe_early;
        @(negedge clk);
        bus.x_new     = nv;
        bus.x_prev    = pv;
        bus.tolerance = tol;
        bus.start     = 1'b1;
        model_push(nv, pv, tol);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_scan", bus.busy, 1'b1);
        if (mid_change) begin
            bus.x_new     = ~nv;
            bus.x_prev    = nv;
            bus.tolerance = '0;
        end
        lat       = 1;
        pwe_early = 0;
        while (bus.done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.prev_write_enable === 1'b1 && bus.done !== 1'b1) pwe_early++;
        end
        check("done_latency", lat, N + 1);
        check("pwe_early", pwe_early, 0);
        compare_done();
        @(negedge clk);
        check("pwe_after",  bus.prev_write_enable, 1'b0);
        check("done_after", bus.done, 1'b0);
        check("busy_after", bus.busy, 1'b0);
    endtask

    initial begin
        vec_t nv, pv;
        int   last_done, n_done;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.x_new     = '0;
        bus.x_prev    = '0;
        bus.tolerance = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",      bus.busy, 1'b0);
        check("rst_pwe",       bus.prev_write_enable, 1'b0);
        check("rst_done",      bus.done, 1'b0);
        check("rst_converged", bus.converged, 1'b0);
        check("rst_max_diff",  bus.max_diff, '0);
        check("rst_iter",      bus.iteration_count, '0);
        check("rst_pwd",       bus.prev_write_data, '0);
        reset = 1'b0;

        // Identical vectors, zero tolerance: converges on the second check.
        run_check(fill(32'd5), fill(32'd5), 32'd0, 1'b0);
        run_check(fill(32'd5), fill(32'd5), 32'd0, 1'b0);

        // Largest difference sits in the last element, just above tolerance.
        pv = fill(32'd10);
        nv = fill(32'd13);
        nv[8*W +: W] = 32'd110;
        run_check(nv, pv, 32'd99, 1'b0);

        // Extreme signed operands: magnitude must not wrap.
        pv = fill(32'd1);
        nv = fill(32'd1);
        nv[0 +: W] = 32'h7FFF_FFFF;
        pv[0 +: W] = 32'h8000_0000;
        run_check(nv, pv, 32'd0, 1'b0);

        // Random vectors; inputs disturbed mid-scan must not affect the result.
        for (int i = 0; i < N; i++) begin
            nv[i*W +: W] = $urandom;
            pv[i*W +: W] = $urandom;
        end
        run_check(nv, pv, 32'hFFFF_FFFF, 1'b1);

        // start held high: one check every N+2 cycles, extra pulses ignored.
        @(negedge clk);
        bus.x_new     = fill(32'd7);
        bus.x_prev    = fill(32'd7);
        bus.tolerance = 32'd0;
        bus.start     = 1'b1;
        repeat (4) model_push(fill(32'd7), fill(32'd7), 32'd0);
        last_done = 0;
        n_done    = 0;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n_done++;
                check("hold_interval", c - last_done, (n_done == 1) ? N + 1 : N + 2);
                last_done = c;
                compare_done();
            end
        end
        bus.start = 1'b0;
        check("hold_done_count", n_done, 4);
        check("hold_sb_drained", sb.size(), 0);

        // Reset on the fourth scan cycle aborts the check.
        @(negedge clk);
        @(negedge clk);
        bus.x_new     = fill(32'd50);
        bus.x_prev    = fill(32'd1);
        bus.tolerance = 32'd0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",      bus.busy, 1'b0);
        check("mid_rst_done",      bus.done, 1'b0);
        check("mid_rst_pwe",       bus.prev_write_enable, 1'b0);
        check("mid_rst_converged", bus.converged, 1'b0);
        check("mid_rst_max_diff",  bus.max_diff, '0);
        check("mid_rst_iter",      bus.iteration_count, '0);
        check("mid_rst_pwd",       bus.prev_write_data, '0);
        reset     = 1'b0;
        bus.start = 1'b0;
        m_stable  = 0;
        m_iter    = 0;
        n_done    = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.prev_write_enable === 1'b1) n_done++;
        end
        check("post_rst_no_done", n_done, 0);
        run_check(fill(32'd5), fill(32'd5), 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
